// File: rtl/board_renderer_pkg.sv
// Shared board geometry, colour constants and pipeline flag bundle for the board renderer.
package board_renderer_pkg;

    localparam int BOARD_SIZE        = 64;
    localparam int LOG_BOARD_SIZE    = 6;
    localparam int WORD_SIZE         = 16;
    localparam int LOG_WORD_SIZE     = 4;
    localparam int WORDS_PER_ROW     = BOARD_SIZE / WORD_SIZE;
    localparam int LOG_WORDS_PER_ROW = LOG_BOARD_SIZE - LOG_WORD_SIZE;
    localparam int MAX_ADDR          = BOARD_SIZE * WORDS_PER_ROW;
    localparam int LOG_MAX_ADDR      = LOG_BOARD_SIZE + LOG_WORDS_PER_ROW;
    localparam int CELL_LOG          = 2;

    typedef logic [11:0] pixel_t;

    localparam pixel_t COLOR_ALIVE  = 12'hFFF;
    localparam pixel_t COLOR_DEAD   = 12'h000;
    localparam pixel_t COLOR_GRID   = 12'h333;
    localparam pixel_t COLOR_CURSOR = 12'hF00;
    localparam pixel_t COLOR_BLANK  = 12'h000;

    typedef struct packed {
        logic                     in_board;
        logic                     grid;
        logic                     cursor;
        logic [LOG_WORD_SIZE-1:0] bit_idx;
        logic                     hsync;
        logic                     vsync;
        logic                     blank;
    } render_flags_t;

    localparam render_flags_t FLAGS_RESET = '{
        in_board: 1'b0,
        grid:     1'b0,
        cursor:   1'b0,
        bit_idx:  '0,
        hsync:    1'b0,
        vsync:    1'b0,
        blank:    1'b1
    };

    // Cell column 0 of a word lives in the MSB.
    function automatic logic [LOG_WORD_SIZE-1:0] word_bit_index(input logic [LOG_WORD_SIZE-1:0] col);
        return LOG_WORD_SIZE'(WORD_SIZE - 1) - col;
    endfunction

endpackage

// File: rtl/board_renderer_if.sv
// Display read port of the double buffer: word address out, word data back.
interface board_renderer_if;
    import board_renderer_pkg::*;

    logic [LOG_MAX_ADDR-1:0] addr_r_out;
    logic [WORD_SIZE-1:0]    data_r_in;

    modport master (output addr_r_out, input data_r_in);
    modport slave  (input addr_r_out, output data_r_in);

endinterface

// File: rtl/board_renderer_render_delay.sv
// WIDTH x DEPTH shift register whose stages reset to a per-bit value.
module render_delay #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_comb begin
        stage_d[0] = data_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign data_out = stage_q[DEPTH-1];

endmodule

// File: rtl/board_renderer.sv
// Turns VGA timing into double-buffer word reads and RGB444 pixels, with cursor blink,
// grid lines, sync signals delay-matched to the read latency, and a per-frame start pulse.
module board_renderer #(
    parameter int CELL_LOG     = board_renderer_pkg::CELL_LOG,
    parameter int READ_LATENCY = 2,
    parameter int V_ACTIVE     = 768,
    parameter int GRID_EN      = 1
) (
    input  logic                                        clk_in,
    input  logic                                        rst_in,
    input  logic [10:0]                                 hcount_in,
    input  logic [9:0]                                  vcount_in,
    input  logic                                        hsync_in,
    input  logic                                        vsync_in,
    input  logic                                        blank_in,
    input  logic [board_renderer_pkg::LOG_BOARD_SIZE-1:0] cursor_x_in,
    input  logic [board_renderer_pkg::LOG_BOARD_SIZE-1:0] cursor_y_in,
    board_renderer_if.master                            rd_bus,
    output board_renderer_pkg::pixel_t                  pixel_out,
    output logic                                        hsync_out,
    output logic                                        vsync_out,
    output logic                                        blank_out,
    output logic                                        frame_start_out
);

    import board_renderer_pkg::*;

    localparam logic [10:0] H_EXTENT = 11'(BOARD_SIZE << CELL_LOG);
    localparam logic [9:0]  V_EXTENT = 10'(BOARD_SIZE << CELL_LOG);
    localparam logic [9:0]  V_START  = 10'(V_ACTIVE);

    logic [LOG_BOARD_SIZE-1:0] cell_x;
    logic [LOG_BOARD_SIZE-1:0] cell_y;
    render_flags_t             flags_now;
    render_flags_t             flags_dly;
    logic                      cell_bit;

    logic [LOG_MAX_ADDR-1:0]   addr_d,        addr_q;
    pixel_t                    pixel_d,       pixel_q;
    logic                      hsync_d,       hsync_q;
    logic                      vsync_d,       vsync_q;
    logic                      blank_d,       blank_q;
    logic                      frame_start_d, frame_start_q;
    logic                      armed_d,       armed_q;
    logic [5:0]                frame_cnt_d,   frame_cnt_q;

    always_comb begin
        cell_x             = LOG_BOARD_SIZE'(hcount_in >> CELL_LOG);
        cell_y             = LOG_BOARD_SIZE'(vcount_in >> CELL_LOG);
        addr_d             = {cell_y, cell_x[LOG_BOARD_SIZE-1:LOG_WORD_SIZE]};
        flags_now          = FLAGS_RESET;
        flags_now.in_board = (hcount_in < H_EXTENT) && (vcount_in < V_EXTENT);
        flags_now.grid     = (hcount_in[CELL_LOG-1:0] == '0) || (vcount_in[CELL_LOG-1:0] == '0);
        flags_now.cursor   = (cell_x == cursor_x_in) && (cell_y == cursor_y_in);
        flags_now.bit_idx  = word_bit_index(cell_x[LOG_WORD_SIZE-1:0]);
        flags_now.hsync    = hsync_in;
        flags_now.vsync    = vsync_in;
        flags_now.blank    = blank_in;
    end

    // Flags enter the delay line unregistered so they meet data_r_in READ_LATENCY cycles on.
    render_delay #(
        .WIDTH     ($bits(render_flags_t)),
        .DEPTH     (READ_LATENCY),
        .RESET_VAL (FLAGS_RESET)
    ) u_flag_delay (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .data_in  (flags_now),
        .data_out (flags_dly)
    );

    always_comb begin
        frame_start_d = armed_q && (hcount_in == '0) && (vcount_in == V_START);
        armed_d       = armed_q;
        frame_cnt_d   = frame_cnt_q;
        if (frame_start_d) begin
            armed_d     = 1'b0;
            frame_cnt_d = frame_cnt_q + 6'd1;
        end else if (vcount_in == '0) begin
            armed_d = 1'b1;
        end
    end

    always_comb begin
        cell_bit = rd_bus.data_r_in[flags_dly.bit_idx];
        hsync_d  = flags_dly.hsync;
        vsync_d  = flags_dly.vsync;
        blank_d  = flags_dly.blank;
        if (flags_dly.blank || !flags_dly.in_board) begin
            pixel_d = COLOR_BLANK;
        end else if (flags_dly.cursor && frame_cnt_q[5]) begin
            pixel_d = COLOR_CURSOR;
        end else if (cell_bit) begin
            pixel_d = COLOR_ALIVE;
        end else if ((GRID_EN != 0) && flags_dly.grid) begin
            pixel_d = COLOR_GRID;
        end else begin
            pixel_d = COLOR_DEAD;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            addr_q        <= '0;
            pixel_q       <= COLOR_BLANK;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b0;
            armed_q       <= 1'b1;
            frame_cnt_q   <= '0;
        end else begin
            addr_q        <= addr_d;
            pixel_q       <= pixel_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_q       <= blank_d;
            frame_start_q <= frame_start_d;
            armed_q       <= armed_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign rd_bus.addr_r_out = addr_q;
    assign pixel_out         = pixel_q;
    assign hsync_out         = hsync_q;
    assign vsync_out         = vsync_q;
    assign blank_out         = blank_q;
    assign frame_start_out   = frame_start_q;

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer: pixel/sync pipeline table, addresses, cursor blink,
// frame-start arming and asynchronous reset.
module tb_board_renderer;
    import board_renderer_pkg::*;

    localparam int LATENCY = 3;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        blank_in;
    logic [5:0]  cursor_x_in;
    logic [5:0]  cursor_y_in;
    pixel_t      pixel_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        blank_out;
    logic        frame_start_out;

    int test_count = 0;
    int fail_count = 0;

    logic [15:0] mem [256];
    logic [15:0] rd_data_q;

    board_renderer_if rd_if();

    board_renderer #(
        .CELL_LOG     (2),
        .READ_LATENCY (2),
        .V_ACTIVE     (768),
        .GRID_EN      (1)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .hcount_in       (hcount_in),
        .vcount_in       (vcount_in),
        .hsync_in        (hsync_in),
        .vsync_in        (vsync_in),
        .blank_in        (blank_in),
        .cursor_x_in     (cursor_x_in),
        .cursor_y_in     (cursor_y_in),
        .rd_bus          (rd_if.master),
        .pixel_out       (pixel_out),
        .hsync_out       (hsync_out),
        .vsync_out       (vsync_out),
        .blank_out       (blank_out),
        .frame_start_out (frame_start_out)
    );

    always #5 clk_in = ~clk_in;

    // Memory model: one read register behind the registered address, so data lands two
    // cycles after the hcount/vcount that produced the address.
    always @(posedge clk_in) rd_data_q <= mem[rd_if.addr_r_out];
    assign rd_if.data_r_in = rd_data_q;

    typedef struct packed {
        logic [10:0] h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        bl;
        logic [11:0] pix;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic [10:0] h, input logic [9:0] v,
                                input logic hs, input logic vs, input logic bl,
                                input logic [11:0] pix);
        vec_t r;
        r.h = h; r.v = v; r.hs = hs; r.vs = vs; r.bl = bl; r.pix = pix;
        return r;
    endfunction

    task automatic applyStimulus(input logic [10:0] h, input logic [9:0] v,
                                 input logic hs, input logic vs, input logic bl,
                                 input logic [5:0] cx, input logic [5:0] cy);
        hcount_in   = h;
        vcount_in   = v;
        hsync_in    = hs;
        vsync_in    = vs;
        blank_in    = bl;
        cursor_x_in = cx;
        cursor_y_in = cy;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkSteady(input string name, input logic [10:0] h, input logic [9:0] v,
                               input logic bl, input logic [5:0] cx, input logic [5:0] cy,
                               input logic [11:0] expected);
        applyStimulus(h, v, 1'b0, 1'b0, bl, cx, cy);
        repeat (LATENCY) @(posedge clk_in);
        #1;
        checkOutput(name, {20'd0, pixel_out}, {20'd0, expected});
    endtask

    task automatic framePulse(output logic seen);
        applyStimulus(11'd5, 10'd0, 1'b0, 1'b0, 1'b1, 6'd40, 6'd40);
        @(posedge clk_in); #1;
        applyStimulus(11'd0, 10'd768, 1'b0, 1'b0, 1'b1, 6'd40, 6'd40);
        @(posedge clk_in); #1;
        seen = frame_start_out;
        applyStimulus(11'd5, 10'd3, 1'b0, 1'b0, 1'b1, 6'd40, 6'd40);
        @(posedge clk_in); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   pulses;
        logic seen;

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]   = 16'h8001;
        mem[255] = 16'h0001;

        vecs[0]  = mk(11'd0,   10'd2,   1'b0, 1'b0, 1'b0, 12'hFFF);
        vecs[1]  = mk(11'd1,   10'd2,   1'b0, 1'b0, 1'b0, 12'hFFF);
        vecs[2]  = mk(11'd2,   10'd2,   1'b0, 1'b0, 1'b0, 12'hFFF);
        vecs[3]  = mk(11'd3,   10'd2,   1'b0, 1'b0, 1'b0, 12'hFFF);
        vecs[4]  = mk(11'd4,   10'd2,   1'b0, 1'b0, 1'b0, 12'h333);
        vecs[5]  = mk(11'd5,   10'd2,   1'b0, 1'b0, 1'b0, 12'h000);
        vecs[6]  = mk(11'd59,  10'd2,   1'b0, 1'b0, 1'b0, 12'h000);
        vecs[7]  = mk(11'd60,  10'd2,   1'b0, 1'b0, 1'b0, 12'hFFF);
        vecs[8]  = mk(11'd61,  10'd2,   1'b1, 1'b0, 1'b0, 12'hFFF);
        vecs[9]  = mk(11'd62,  10'd2,   1'b0, 1'b0, 1'b0, 12'hFFF);
        vecs[10] = mk(11'd63,  10'd2,   1'b0, 1'b0, 1'b0, 12'hFFF);
        vecs[11] = mk(11'd64,  10'd2,   1'b0, 1'b0, 1'b0, 12'h333);
        vecs[12] = mk(11'd66,  10'd0,   1'b0, 1'b1, 1'b0, 12'h333);
        vecs[13] = mk(11'd256, 10'd2,   1'b1, 1'b1, 1'b0, 12'h000);
        vecs[14] = mk(11'd1,   10'd2,   1'b0, 1'b0, 1'b1, 12'h000);
        vecs[15] = mk(11'd1,   10'd256, 1'b0, 1'b0, 1'b0, 12'h000);
        vecs[16] = mk(11'd253, 10'd253, 1'b0, 1'b0, 1'b0, 12'hFFF);
        vecs[17] = mk(11'd252, 10'd253, 1'b0, 1'b0, 1'b0, 12'hFFF);
        vecs[18] = mk(11'd248, 10'd253, 1'b0, 1'b0, 1'b0, 12'h333);
        vecs[19] = mk(11'd250, 10'd254, 1'b0, 1'b0, 1'b0, 12'h000);

        applyStimulus(11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 6'd40, 6'd40);
        repeat (3) @(posedge clk_in);
        #1;
        checkOutput("reset_pixel", {20'd0, pixel_out}, 32'h000);
        checkOutput("reset_syncs", {29'd0, hsync_out, vsync_out, blank_out}, 32'b001);
        checkOutput("reset_addr", {24'd0, rd_if.addr_r_out}, 32'd0);
        checkOutput("reset_frame_start", {31'd0, frame_start_out}, 32'd0);

        rst_in = 1'b0;
        applyStimulus(11'd1, 10'd2, 1'b0, 1'b0, 1'b0, 6'd40, 6'd40);
        @(posedge clk_in); #1;
        checkOutput("blank_after_release", {31'd0, blank_out}, 32'd1);
        repeat (LATENCY) @(posedge clk_in);
        #1;

        // Back-to-back vectors: vector j shows up after the edge two loop iterations later.
        for (int j = 0; j < NVEC + LATENCY - 1; j++) begin
            if (j < NVEC) begin
                applyStimulus(vecs[j].h, vecs[j].v, vecs[j].hs, vecs[j].vs, vecs[j].bl,
                              6'd40, 6'd40);
            end
            @(posedge clk_in); #1;
            if (j >= LATENCY - 1) begin
                checkOutput($sformatf("vec%0d", j - (LATENCY - 1)),
                            {17'd0, hsync_out, vsync_out, blank_out, pixel_out},
                            {17'd0, vecs[j-(LATENCY-1)].hs, vecs[j-(LATENCY-1)].vs,
                             vecs[j-(LATENCY-1)].bl, vecs[j-(LATENCY-1)].pix});
            end
        end

        applyStimulus(11'd100, 10'd12, 1'b0, 1'b0, 1'b0, 6'd40, 6'd40);
        @(posedge clk_in); #1;
        checkOutput("addr_cell_25_3", {24'd0, rd_if.addr_r_out}, 32'd13);
        applyStimulus(11'd255, 10'd255, 1'b0, 1'b0, 1'b0, 6'd40, 6'd40);
        @(posedge clk_in); #1;
        checkOutput("addr_last_word", {24'd0, rd_if.addr_r_out}, 32'd255);
        applyStimulus(11'd64, 10'd4, 1'b0, 1'b0, 1'b0, 6'd40, 6'd40);
        @(posedge clk_in); #1;
        checkOutput("addr_row1_word1", {24'd0, rd_if.addr_r_out}, 32'd5);

        checkSteady("cursor_off_grid",  11'd8, 10'd1, 1'b0, 6'd2, 6'd0, 12'h333);
        checkSteady("cursor_off_dead",  11'd9, 10'd1, 1'b0, 6'd2, 6'd0, 12'h000);
        checkSteady("cursor_off_alive", 11'd1, 10'd2, 1'b0, 6'd0, 6'd0, 12'hFFF);

        applyStimulus(11'd0, 10'd768, 1'b0, 1'b0, 1'b1, 6'd40, 6'd40);
        @(posedge clk_in); #1;
        checkOutput("fs_next_cycle", {31'd0, frame_start_out}, 32'd1);
        pulses = 1;
        repeat (9) begin
            @(posedge clk_in); #1;
            pulses += int'(frame_start_out);
        end
        checkOutput("fs_held_once", pulses, 32'd1);
        pulses = 0;
        applyStimulus(11'd0, 10'd767, 1'b0, 1'b0, 1'b1, 6'd40, 6'd40);
        repeat (3) begin
            @(posedge clk_in); #1;
            pulses += int'(frame_start_out);
        end
        applyStimulus(11'd0, 10'd768, 1'b0, 1'b0, 1'b1, 6'd40, 6'd40);
        repeat (3) begin
            @(posedge clk_in); #1;
            pulses += int'(frame_start_out);
        end
        checkOutput("fs_not_rearmed", pulses, 32'd0);
        framePulse(seen);
        checkOutput("fs_rearmed", {31'd0, seen}, 32'd1);

        pulses = 0;
        for (int k = 0; k < 32; k++) begin
            framePulse(seen);
            pulses += int'(seen);
        end
        checkOutput("fs_pulse_count", pulses, 32'd32);

        checkSteady("cursor_on_grid",   11'd8,   10'd1, 1'b0, 6'd2, 6'd0, 12'hF00);
        checkSteady("cursor_on_dead",   11'd11,  10'd1, 1'b0, 6'd2, 6'd0, 12'hF00);
        checkSteady("cursor_on_alive",  11'd1,   10'd2, 1'b0, 6'd0, 6'd0, 12'hF00);
        checkSteady("cursor_neighbour", 11'd13,  10'd1, 1'b0, 6'd2, 6'd0, 12'h000);
        checkSteady("cursor_off_board", 11'd264, 10'd1, 1'b0, 6'd2, 6'd0, 12'h000);
        checkSteady("cursor_blanked",   11'd9,   10'd1, 1'b1, 6'd2, 6'd0, 12'h000);
        checkSteady("pre_reset_cursor", 11'd1,   10'd2, 1'b0, 6'd0, 6'd0, 12'hF00);

        #3;
        rst_in = 1'b1;
        #1;
        checkOutput("async_reset_pixel", {20'd0, pixel_out}, 32'h000);
        checkOutput("async_reset_blank", {31'd0, blank_out}, 32'd1);
        repeat (5) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        checkSteady("post_reset_alive", 11'd1, 10'd2, 1'b0, 6'd0, 6'd0, 12'hFFF);
        checkSteady("post_reset_grid",  11'd8, 10'd1, 1'b0, 6'd2, 6'd0, 12'h333);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
